pixel_frame_sequencer: RTL and testbench
========================================

PIXEL_FRAME_SEQUENCER -- requirements
Module: pixel_frame_sequencer

Interface
REQ-001 SHALL have parameter GS_BITS, default 8, pixel width in bits.
REQ-002 SHALL have parameter BCD_BITS, default 4, digit result width.
REQ-003 SHALL have parameter IMG_DIM, default 30, output frame side length in pixels.
REQ-004 SHALL have parameter FIFO_DEPTH, default 1024, input buffer depth as a power of two.
REQ-005 SHALL have parameter PAD_VALUE, default 8'h00, border pixel value (used only with the padding feature).
REQ-006 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst.
REQ-007 SHALL have ports: clk  in  1  clock (rising edge); rst  in  1  async active-low reset.
REQ-008 SHALL have ports: src_pixel  in  GS_BITS  upstream pixel; src_valid  in  1  upstream valid; src_ready  out  1  space available.
REQ-009 SHALL have ports: pixel_o  out  GS_BITS  pixel to CNN; pixel_o_valid  out  1  pixel strobe (CNN has no backpressure).
REQ-010 SHALL have ports: digit_i  in  BCD_BITS  CNN result; digit_i_valid  in  1  result strobe.
REQ-011 SHALL have ports: digit_o  out  BCD_BITS  latched result; digit_o_valid  out  1  one-cycle result pulse; frame_count  out  32  completed frames; proto_err  out  1  sticky protocol error.

Function
REQ-012 SHALL accept a source pixel into the internal FIFO on any clock edge with src_valid=1 and src_ready=1; src_ready SHALL equal not-full.
REQ-013 SHALL implement two states: SEND and WAIT; reset state SEND.
REQ-014 In SEND, each cycle the FIFO is non-empty, SHALL pop one pixel; pixel_o/pixel_o_valid SHALL be registered and appear the cycle after the pop.
REQ-015 Latency: a pixel written into an empty FIFO at edge N SHALL be popped at edge N+1 and presented on pixel_o at edge N+2.
REQ-016 SHALL count emitted pixels 0..IMG_DIM*IMG_DIM-1; on popping the last pixel of a frame SHALL move to WAIT and clear the count.
REQ-017 In WAIT, SHALL not pop and pixel_o_valid SHALL be 0 (from the cycle after the last pixel); FIFO writes continue.
REQ-018 In WAIT, on digit_i_valid=1: latch digit_o<=digit_i, pulse digit_o_valid for one cycle, increment frame_count (wraps 2^32-1 -> 0), return to SEND; first pop of next frame no earlier than the following cycle.
REQ-019 digit_i_valid in SEND SHALL be ignored for data and SHALL set proto_err, which stays 1 until reset.
REQ-020 Simultaneous FIFO write and read SHALL be allowed at any occupancy; write when full and read when empty SHALL not occur.
REQ-021 FIFO full: src_ready=0, no data lost; FIFO empty in SEND: emission pauses, pixel count held.

Reset
REQ-022 On rst=0: state SEND, FIFO emptied, pixel count 0, pixel_o=0, pixel_o_valid=0, digit_o=0, digit_o_valid=0, frame_count=0, proto_err=0, src_ready=0 while rst asserted.
REQ-023 Reset mid-frame SHALL discard buffered and partially sent pixels; next frame starts at count 0.

Configuration
REQ-024 Macro PIXEL_PAD_BORDER_EN SHALL select border padding.
REQ-025 With PIXEL_PAD_BORDER_EN defined: input frame is (IMG_DIM-2)^2 pixels; output row/col 0 or IMG_DIM-1 SHALL emit PAD_VALUE without popping (even if FIFO empty); interior positions pop, stalling only when empty; output frame remains IMG_DIM^2 pixels.
REQ-026 Without PIXEL_PAD_BORDER_EN: every output pixel is popped from the FIFO; no row/col logic, PAD_VALUE unused.

Verification
REQ-027 Pad off, IMG_DIM=30: push 900 pixels 0x00..0x83 ramp (mod 256) back-to-back -> exactly 900 pixel_o_valid pulses in order, first at cycle 2 after first accept, then WAIT.
REQ-028 In WAIT, pulse digit_i_valid with digit_i=7 -> digit_o=7, digit_o_valid high 1 cycle, frame_count=1, second frame emission resumes.
REQ-029 FIFO_DEPTH=16, hold CNN in WAIT, push 20 pixels -> src_ready falls after 16 accepts; all 20 emitted in order after digit_i_valid.
REQ-030 Pulse digit_i_valid during SEND at pixel 100 -> proto_err=1, digit_o unchanged, pixel stream uninterrupted.
REQ-031 Assert rst at pixel 450 of frame, then push 900 pixels -> output frame starts at count 0 with the new data, frame_count=0, proto_err=0.
REQ-032 PIXEL_PAD_BORDER_EN, PAD_VALUE=0xFF: push 784 pixels value 0x11 -> 900 outputs, 116 border 0xFF at rows/cols 0 and 29, 784 interior 0x11.

Source files
------------

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: buffers an upstream pixel stream in a FIFO, emits one
// IMG_DIM x IMG_DIM frame to the CNN, then waits for the digit result before
// starting the next frame.
// Optional build macro PIXEL_PAD_BORDER_EN: the outer ring of each output frame
// is generated as PAD_VALUE, and only interior pixels come from the FIFO.
//
// state | meaning
// SEND  | emitting pixels of the current frame (pops FIFO when data available)
// WAIT  | frame fully emitted, holding until the CNN returns digit_i_valid
module pixel_frame_sequencer #(
   parameter int                 GS_BITS    = 8,
   parameter int                 BCD_BITS   = 4,
   parameter int                 IMG_DIM    = 30,
   parameter int                 FIFO_DEPTH = 1024,
   parameter logic [GS_BITS-1:0] PAD_VALUE  = 8'h00
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [GS_BITS-1:0]  src_pixel,
   input  logic                src_valid,
   output logic                src_ready,
   output logic [GS_BITS-1:0]  pixel_o,
   output logic                pixel_o_valid,
   input  logic [BCD_BITS-1:0] digit_i,
   input  logic                digit_i_valid,
   output logic [BCD_BITS-1:0] digit_o,
   output logic                digit_o_valid,
   output logic [31:0]         frame_count,
   output logic                proto_err
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {ST_SEND = 1'b0, ST_WAIT = 1'b1} state_t;

   logic [GS_BITS-1:0]  fifo_mem [FIFO_DEPTH];
   logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                run_q;
   state_t              state_q, state_d;
   logic [GS_BITS-1:0]  stg_data_q, stg_data_d;
   logic                stg_vld_q, stg_vld_d;
   logic [GS_BITS-1:0]  pixel_o_q, pixel_o_d;
   logic                pixel_o_valid_q, pixel_o_valid_d;
   logic [BCD_BITS-1:0] digit_o_q, digit_o_d;
   logic                digit_o_valid_q, digit_o_valid_d;
   logic [31:0]         frame_count_q, frame_count_d;
   logic                proto_err_q, proto_err_d;
   logic                full, empty, push, pop, advance, last_pix;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // run_q keeps src_ready low while reset is held and until the first edge after release
   assign src_ready = run_q & ~full;
   assign push      = src_valid & src_ready;

`ifdef PIXEL_PAD_BORDER_EN
   localparam int RW = $clog2(IMG_DIM);
   localparam logic [RW-1:0] LAST_IDX = RW'(IMG_DIM - 1);

   logic [RW-1:0] row_q, row_d, col_q, col_d;
   logic          border;

   assign border   = (row_q == '0) || (row_q == LAST_IDX) || (col_q == '0) || (col_q == LAST_IDX);
   assign advance  = (state_q == ST_SEND) && (border || !empty);
   assign pop      = (state_q == ST_SEND) && !border && !empty;
   assign last_pix = (row_q == LAST_IDX) && (col_q == LAST_IDX);

   // raster position of the next output pixel
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (advance) begin
         if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = (row_q == LAST_IDX) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + RW'(1);
         end
      end
   end

   // raster position registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end
`else
   localparam int NPIX = IMG_DIM * IMG_DIM;
   localparam int CW   = $clog2(NPIX);

   logic [CW-1:0] pix_cnt_q, pix_cnt_d;

   assign pop      = (state_q == ST_SEND) && !empty;
   assign advance  = pop;
   assign last_pix = (pix_cnt_q == CW'(NPIX - 1));

   // emitted-pixel counter, cleared when the frame's last pixel is popped
   always_comb begin
      pix_cnt_d = pix_cnt_q;
      if (advance) pix_cnt_d = last_pix ? '0 : pix_cnt_q + CW'(1);
   end

   // pixel counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pix_cnt_q <= '0;
      else      pix_cnt_q <= pix_cnt_d;
   end
`endif

   // FIFO storage; no reset needed since pointers define validity
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= src_pixel;
   end

   // next-state, pointer, output-pipeline and result logic
   always_comb begin
      wr_ptr_d        = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d        = rd_ptr_q + {{AW{1'b0}}, pop};
      stg_data_d      = pop ? fifo_mem[rd_ptr_q[AW-1:0]] : PAD_VALUE;
      stg_vld_d       = advance;
      pixel_o_d       = stg_vld_q ? stg_data_q : pixel_o_q;
      pixel_o_valid_d = stg_vld_q;
      state_d         = state_q;
      digit_o_d       = digit_o_q;
      digit_o_valid_d = 1'b0;
      frame_count_d   = frame_count_q;
      proto_err_d     = proto_err_q | ((state_q == ST_SEND) & digit_i_valid);
      case (state_q)
         ST_SEND: begin
            if (advance && last_pix) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (digit_i_valid) begin
               digit_o_d       = digit_i;
               digit_o_valid_d = 1'b1;
               frame_count_d   = frame_count_q + 32'd1;
               state_d         = ST_SEND;
            end
         end
         default: state_d = ST_SEND;
      endcase
   end

   // FSM and all registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q           <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         state_q         <= ST_SEND;
         stg_data_q      <= '0;
         stg_vld_q       <= 1'b0;
         pixel_o_q       <= '0;
         pixel_o_valid_q <= 1'b0;
         digit_o_q       <= '0;
         digit_o_valid_q <= 1'b0;
         frame_count_q   <= '0;
         proto_err_q     <= 1'b0;
      end else begin
         run_q           <= 1'b1;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         state_q         <= state_d;
         stg_data_q      <= stg_data_d;
         stg_vld_q       <= stg_vld_d;
         pixel_o_q       <= pixel_o_d;
         pixel_o_valid_q <= pixel_o_valid_d;
         digit_o_q       <= digit_o_d;
         digit_o_valid_q <= digit_o_valid_d;
         frame_count_q   <= frame_count_d;
         proto_err_q     <= proto_err_d;
      end
   end

   assign pixel_o       = pixel_o_q;
   assign pixel_o_valid = pixel_o_valid_q;
   assign digit_o       = digit_o_q;
   assign digit_o_valid = digit_o_valid_q;
   assign frame_count   = frame_count_q;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
module tb_pixel_frame_sequencer;

   localparam int DIM  = 30;
   localparam int NPIX = DIM * DIM;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  src_pixel = '0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [7:0]  pixel_o;
   logic        pixel_o_valid;
   logic [3:0]  digit_i = '0;
   logic        digit_i_valid = 1'b0;
   logic [3:0]  digit_o;
   logic        digit_o_valid;
   logic [31:0] frame_count;
   logic        proto_err;

   pixel_frame_sequencer #(
      .GS_BITS(8), .BCD_BITS(4), .IMG_DIM(DIM), .FIFO_DEPTH(16), .PAD_VALUE(8'hFF)
   ) dut (
      .clk(clk), .rst(rst),
      .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
      .pixel_o(pixel_o), .pixel_o_valid(pixel_o_valid),
      .digit_i(digit_i), .digit_i_valid(digit_i_valid),
      .digit_o(digit_o), .digit_o_valid(digit_o_valid),
      .frame_count(frame_count), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] out_q[$];
   int         out_cyc[$];
   int         dvalid_cnt = 0;

   // record every emitted pixel and result pulse shortly after the edge
   always @(posedge clk) begin
      #2;
      if (pixel_o_valid === 1'b1) begin
         out_q.push_back(pixel_o);
         out_cyc.push_back(cyc);
      end
      if (digit_o_valid === 1'b1) dvalid_cnt++;
   end

   int passed = 0;
   int total  = 0;
   int failed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // called at a falling edge; returns at the falling edge after the accepting edge
   task automatic push_px(input logic [7:0] v, output int acc_cyc);
      int k;
      k = 0;
      src_pixel = v;
      src_valid = 1'b1;
      while (src_ready !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) chk("push_timeout", k, 0);
      @(negedge clk);
      acc_cyc = cyc;
   endtask

   task automatic wait_out(input int n, input string tag);
      int k;
      k = 0;
      while (out_q.size() < n && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(k < 5000), 1);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      src_valid = 1'b0;
      digit_i_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, "_src_ready"}, 32'(src_ready), 0);
      chk({tag, "_pix_valid"}, 32'(pixel_o_valid), 0);
      chk({tag, "_pix"}, 32'(pixel_o), 0);
      chk({tag, "_digit_o"}, 32'(digit_o), 0);
      chk({tag, "_digit_valid"}, 32'(digit_o_valid), 0);
      chk({tag, "_frame_count"}, frame_count, 0);
      chk({tag, "_proto_err"}, 32'(proto_err), 0);
      out_q.delete();
      out_cyc.delete();
      dvalid_cnt = 0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_digit(input logic [3:0] d);
      digit_i = d;
      digit_i_valid = 1'b1;
      @(negedge clk);
      digit_i_valid = 1'b0;
   endtask

   initial begin
      int a, first_acc, bad, n_ff, n_11;
      logic [7:0] exp_v;

`ifdef PIXEL_PAD_BORDER_EN
      apply_reset("rst0");
      for (int i = 0; i < 784; i++) push_px(8'h11, a);
      src_valid = 1'b0;
      wait_out(NPIX, "pad_done");
      repeat (10) @(negedge clk);
      chk("pad_count", out_q.size(), NPIX);
      bad = 0; n_ff = 0; n_11 = 0;
      for (int p = 0; p < out_q.size(); p++) begin
         exp_v = ((p / DIM) == 0 || (p / DIM) == DIM - 1 || (p % DIM) == 0 || (p % DIM) == DIM - 1)
                 ? 8'hFF : 8'h11;
         if (out_q[p] !== exp_v) bad++;
         if (out_q[p] === 8'hFF) n_ff++;
         if (out_q[p] === 8'h11) n_11++;
      end
      chk("pad_positions", bad, 0);
      chk("pad_border_n", n_ff, 116);
      chk("pad_interior_n", n_11, 784);
      pulse_digit(4'd3);
      chk("pad_digit_o", 32'(digit_o), 3);
      chk("pad_frame_count", frame_count, 1);
`else
      // reset state, then frame 1: ramp with a stray result at pixel 100
      apply_reset("rst0");
      first_acc = 0;
      for (int i = 0; i < NPIX; i++) begin
         if (i == 100) begin
            digit_i = 4'd5;
            digit_i_valid = 1'b1;
         end
         if (i == 101) digit_i_valid = 1'b0;
         push_px(8'(i), a);
         if (i == 0) first_acc = a;
      end
      src_valid = 1'b0;
      wait_out(NPIX, "f1_done");
      repeat (10) @(negedge clk);
      chk("f1_count", out_q.size(), NPIX);
      chk("f1_latency", out_cyc[0] - first_acc, 2);
      chk("f1_contiguous", out_cyc[NPIX-1] - out_cyc[0], NPIX - 1);
      bad = 0;
      for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'(i)) bad++;
      chk("f1_order", bad, 0);
      chk("f1_last_pix", 32'(out_q[NPIX-1]), 32'h83);
      chk("f1_proto_err", 32'(proto_err), 1);
      chk("f1_digit_o_held", 32'(digit_o), 0);
      chk("f1_no_digit_pulse", dvalid_cnt, 0);
      chk("f1_frame_count", frame_count, 0);

      // WAIT with a full FIFO
      out_q.delete();
      out_cyc.delete();
      for (int i = 0; i < 16; i++) push_px(8'hA0 + 8'(i), a);
      src_valid = 1'b0;
      @(negedge clk);
      chk("full_src_ready", 32'(src_ready), 0);
      chk("wait_no_emit", out_q.size(), 0);
      chk("wait_pix_valid", 32'(pixel_o_valid), 0);

      // result returns, frame 2 starts
      pulse_digit(4'd7);
      chk("res_digit_o", 32'(digit_o), 7);
      chk("res_digit_valid", 32'(digit_o_valid), 1);
      chk("res_frame_count", frame_count, 1);
      @(negedge clk);
      chk("res_pulse_width", 32'(digit_o_valid), 0);
      for (int i = 16; i < 20; i++) push_px(8'hA0 + 8'(i), a);
      for (int i = 20; i < 450; i++) push_px(8'h55, a);
      src_valid = 1'b0;
      wait_out(450, "f2_half");
      bad = 0;
      for (int i = 0; i < 20 && i < out_q.size(); i++) if (out_q[i] !== 8'hA0 + 8'(i)) bad++;
      chk("f2_order", bad, 0);
      chk("f2_digit_o", 32'(digit_o), 7);

      // reset mid-frame, then a fresh frame
      apply_reset("rst1");
      for (int i = 0; i < NPIX; i++) begin
         push_px(8'(i * 3 + 1), a);
         if (i == 0) first_acc = a;
      end
      src_valid = 1'b0;
      wait_out(NPIX, "f3_done");
      repeat (5) @(negedge clk);
      chk("f3_count", out_q.size(), NPIX);
      chk("f3_latency", out_cyc[0] - first_acc, 2);
      bad = 0;
      for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'(i * 3 + 1)) bad++;
      chk("f3_order", bad, 0);
      chk("f3_frame_count", frame_count, 0);
      push_px(8'h99, a);
      src_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("f3_wait_holds", out_q.size(), NPIX);
      pulse_digit(4'd9);
      chk("f3_digit_o", 32'(digit_o), 9);
      chk("f3_frame_count_inc", frame_count, 1);
      repeat (5) @(negedge clk);
      chk("f4_resume", out_q.size(), NPIX + 1);
      chk("f4_first_pix", 32'(out_q[out_q.size()-1]), 32'h99);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
